// File: rtl/processor_wrapper.sv
// Display subsystem: hard-wired checkerboard drawing controller, 160x120 1-bit
// frame buffer and VGA timing generator producing RRRGGGBB colour with
// active-low syncs. Counters run at CLK/4; the pixel pipeline is two registers deep.
module processor_wrapper #(
  parameter int         H_VIS     = 640,
  parameter int         H_FP      = 16,
  parameter int         H_SYNC    = 96,
  parameter int         H_BP      = 48,
  parameter int         V_VIS     = 480,
  parameter int         V_FP      = 10,
  parameter int         V_SYNC    = 2,
  parameter int         V_BP      = 33,
  parameter logic [7:0] FG_INIT   = 8'h1C,
  parameter logic [7:0] BG_COLOUR = 8'h00
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic [7:0] VGA_COLOUR,
  output logic       VGA_HS,
  output logic       VGA_VS
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HC_W  = $clog2(H_TOT);
  localparam int VC_W  = $clog2(V_TOT);

  localparam logic [HC_W-1:0] H_LAST   = HC_W'(H_TOT - 1);
  localparam logic [HC_W-1:0] H_VIS_C  = HC_W'(H_VIS);
  localparam logic [HC_W-1:0] HS_FIRST = HC_W'(H_VIS + H_FP);
  localparam logic [HC_W-1:0] HS_LAST  = HC_W'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [VC_W-1:0] V_LAST   = VC_W'(V_TOT - 1);
  localparam logic [VC_W-1:0] V_VIS_C  = VC_W'(V_VIS);
  localparam logic [VC_W-1:0] VS_FIRST = VC_W'(V_VIS + V_FP);
  localparam logic [VC_W-1:0] VS_LAST  = VC_W'(V_VIS + V_FP + V_SYNC - 1);

  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int FB_DEPTH = FB_W * FB_H;
  localparam int AW       = 15;

  localparam logic [AW-1:0] FB_LAST = AW'(FB_DEPTH - 1);
  localparam logic [AW-1:0] FB_END  = AW'(FB_DEPTH);
  localparam logic [7:0]    FX_LAST = 8'(FB_W - 1);

  logic [1:0]      div;
  logic            pix_en;
  logic [HC_W-1:0] hcnt;
  logic [VC_W-1:0] vcnt;

  logic [AW-1:0]   fill_addr;
  logic [7:0]      fill_x;
  logic [6:0]      fill_y;
  logic            init_done;
  logic [7:0]      fg;

  logic            fb [0:FB_DEPTH-1];
  logic [AW-1:0]   rd_addr;

  logic            hs_p0;
  logic            vs_p0;
  logic            vis_p0;
  logic            px_p0;

  assign pix_en  = (div == 2'd3);
  // Each frame-buffer cell covers a 4x4 block of screen pixels.
  assign rd_addr = AW'(vcnt[VC_W-1:2]) * AW'(FB_W) + AW'(hcnt[HC_W-1:2]);

  // Pixel-clock divider and horizontal/vertical raster counters.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      div  <= 2'd0;
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      div <= div + 2'd1;
      if (pix_en) begin
        if (hcnt == H_LAST) begin
          hcnt <= '0;
          vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end else begin
          hcnt <= hcnt + 1'b1;
        end
      end
    end
  end

  // Init fill walks every cell once, tracking x/y alongside the linear address.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      fill_addr <= '0;
      fill_x    <= 8'd0;
      fill_y    <= 7'd0;
      init_done <= 1'b0;
    end else if (!init_done) begin
      if (fill_addr == FB_LAST) begin
        init_done <= 1'b1;
      end else begin
        fill_addr <= fill_addr + 1'b1;
        if (fill_x == FX_LAST) begin
          fill_x <= 8'd0;
          fill_y <= fill_y + 7'd1;
        end else begin
          fill_x <= fill_x + 8'd1;
        end
      end
    end
  end

  // Foreground colour steps once per frame, on the last pixel of the frame.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      fg <= FG_INIT;
    end else if (pix_en && init_done && (hcnt == H_LAST) && (vcnt == V_LAST)) begin
      fg <= fg + 8'd1;
    end
  end

  // Frame buffer: fill-port write, synchronous pixel read (stage p0 data).
  always_ff @(posedge CLK) begin
    if (!init_done) begin
      fb[fill_addr] <= fill_x[2] ^ fill_y[2];
    end
    px_p0 <= (rd_addr < FB_END) ? fb[rd_addr] : 1'b0;
  end

  // Stage p0: sync and visibility decode, aligned with the frame-buffer read.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hs_p0  <= 1'b1;
      vs_p0  <= 1'b1;
      vis_p0 <= 1'b0;
    end else begin
      hs_p0  <= !((hcnt >= HS_FIRST) && (hcnt <= HS_LAST));
      vs_p0  <= !((vcnt >= VS_FIRST) && (vcnt <= VS_LAST));
      vis_p0 <= (hcnt < H_VIS_C) && (vcnt < V_VIS_C);
    end
  end

  // Stage p1: registered outputs; colour blanked outside the visible area and during fill.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      VGA_HS     <= 1'b1;
      VGA_VS     <= 1'b1;
      VGA_COLOUR <= 8'h00;
    end else begin
      VGA_HS     <= hs_p0;
      VGA_VS     <= vs_p0;
      VGA_COLOUR <= (vis_p0 && init_done) ? (px_p0 ? fg : BG_COLOUR) : 8'h00;
    end
  end

endmodule

// File: tb/tb_processor_wrapper.sv
// Bench for processor_wrapper with a shrunken raster so several frames fit in
// a short run. Expected outputs are computed from the elapsed clock count
// since the last reset edge using plain raster arithmetic.
module tb_processor_wrapper;

  localparam int H_VIS  = 32;
  localparam int H_FP   = 4;
  localparam int H_SYNC = 8;
  localparam int H_BP   = 4;
  localparam int V_VIS  = 32;
  localparam int V_FP   = 2;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 2;
  localparam logic [7:0] FG_INIT   = 8'h1C;
  localparam logic [7:0] BG_COLOUR = 8'h00;

  localparam int HT        = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int VT        = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int NPIX      = HT * VT;
  localparam int FILL_CLKS = 19200;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] VGA_COLOUR;
  logic       VGA_HS;
  logic       VGA_VS;

  int checks = 0;
  int errors = 0;
  int k      = 0;

  processor_wrapper #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .FG_INIT(FG_INIT), .BG_COLOUR(BG_COLOUR)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .VGA_COLOUR(VGA_COLOUR),
    .VGA_HS    (VGA_HS),
    .VGA_VS    (VGA_VS)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at k=%0d: got {hs,vs,colour}=%h, expected %h", tag, k, got, exp);
    end
  endtask

  // Expected {HS, VS, COLOUR} after the k-th clock edge following reset.
  function automatic logic [9:0] expected(input int kk);
    int   p, h, v, f, steps;
    logic hs, vs, bit_on;
    logic [7:0] col, fgv;
    if (kk < 2) return {1'b1, 1'b1, 8'h00};
    // Counters advance on edges 4,8,12,...; outputs trail them by two clocks.
    p  = (kk - 2) / 4;
    h  = p % HT;
    v  = (p / HT) % VT;
    f  = p / NPIX;
    hs = !(h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC);
    vs = !(v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC);
    col = 8'h00;
    if (h < H_VIS && v < V_VIS && kk > FILL_CLKS) begin
      // Frame boundaries reached after the fill finished each bump the foreground.
      steps = 0;
      for (int j = 1; j <= f; j++)
        if (4 * j * NPIX > FILL_CLKS) steps++;
      fgv    = FG_INIT + 8'(steps);
      bit_on = ((h / 16) + (v / 16)) % 2 == 1;
      col    = bit_on ? fgv : BG_COLOUR;
    end
    return {hs, vs, col};
  endfunction

  task automatic cycle();
    string tag;
    @(posedge CLK);
    #1;
    if (RESET) k = 0;
    else       k = k + 1;
    if (k < 2)               tag = "reset";
    else if (k <= FILL_CLKS) tag = "fill";
    else                     tag = "video";
    check(tag, {22'd0, VGA_HS, VGA_VS, VGA_COLOUR}, {22'd0, expected(k)});
  endtask

  initial begin
    int n;
    RESET = 1'b1;
    n = 1 + $urandom_range(0, 2);
    repeat (n) cycle();
    RESET = 1'b0;
    // Fill plus three animated frame boundaries, then a reset at a random point.
    n = 40000 + $urandom_range(0, 3000);
    repeat (n) cycle();
    RESET = 1'b1;
    n = 1 + $urandom_range(0, 2);
    repeat (n) cycle();
    RESET = 1'b0;
    n = FILL_CLKS + 4 * NPIX + $urandom_range(0, 2000);
    repeat (n) cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
